// File: rtl/npu_cq_fetch.sv
// Command-queue fetch stage: walks the descriptor ring from head up to the
// doorbell-latched tail with one read outstanding, handing each descriptor out on valid/ready.
module npu_cq_fetch #(
   parameter int ADDR_W = 64,
   parameter int PTR_W  = 32,
   parameter int DESC_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [PTR_W-1:0]  cfg_size,
   input  logic [PTR_W-1:0]  cfg_tail,
   input  logic              doorbell,
   output logic [PTR_W-1:0]  head,
   output logic              busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DESC_W-1:0] mem_rsp_data,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [DESC_W-1:0] desc_data,
   output logic [7:0]        desc_opcode,
   output logic              irq_cq_empty,
   output logic              irq_cfg_err
);

   localparam int               DESC_BYTES = DESC_W / 8;
   localparam logic [PTR_W-1:0] STRIDE     = PTR_W'(DESC_BYTES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t            state_reg;
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic              mem_req_valid_reg;
   logic              desc_valid_reg;
   logic              irq_cq_empty_reg;
   logic              irq_cfg_err_reg;

   logic              cfg_ok;
   logic              db_accept;
   logic              rsp_fire;
   logic [PTR_W-1:0]  tail_next;
   logic [PTR_W-1:0]  head_inc;
   logic [PTR_W-1:0]  head_next;

   // Ring geometry and tail must both sit on descriptor boundaries, tail inside the ring.
   assign cfg_ok    = (cfg_size != '0) && (cfg_size[4:0] == 5'd0) &&
                      (cfg_tail[4:0] == 5'd0) && (cfg_tail < cfg_size);
   assign db_accept = doorbell && cfg_ok;

   // A doorbell landing this cycle already counts for the drain decision.
   assign tail_next = db_accept ? cfg_tail : tail_reg;
   assign head_inc  = head_reg + STRIDE;
   assign head_next = (head_inc == cfg_size) ? '0 : head_inc;
   assign rsp_fire  = (state_reg == WAIT) && mem_rsp_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         head_reg          <= '0;
         tail_reg          <= '0;
         mem_req_valid_reg <= 1'b0;
         desc_valid_reg    <= 1'b0;
         irq_cq_empty_reg  <= 1'b0;
         irq_cfg_err_reg   <= 1'b0;
      end else begin
         irq_cq_empty_reg <= 1'b0;
         irq_cfg_err_reg  <= doorbell && !cfg_ok;
         tail_reg         <= tail_next;
         case (state_reg)
            IDLE: begin
               if (head_reg != tail_next) begin
                  state_reg         <= REQ;
                  mem_req_valid_reg <= 1'b1;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state_reg         <= WAIT;
                  mem_req_valid_reg <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  state_reg      <= OUT;
                  desc_valid_reg <= 1'b1;
               end
            end
            OUT: begin
               if (desc_ready) begin
                  desc_valid_reg <= 1'b0;
                  head_reg       <= head_next;
                  if (head_next != tail_next) begin
                     state_reg         <= REQ;
                     mem_req_valid_reg <= 1'b1;
                  end else begin
                     state_reg        <= IDLE;
                     irq_cq_empty_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg         <= IDLE;
               mem_req_valid_reg <= 1'b0;
               desc_valid_reg    <= 1'b0;
            end
         endcase
      end
   end

   // Descriptor holding register, one byte lane per generate slice.
   genvar gi;
   generate
      for (gi = 0; gi < DESC_BYTES; gi++) begin : g_byte
         logic [7:0] byte_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               byte_reg <= 8'h00;
            end else if (rsp_fire) begin
               byte_reg <= mem_rsp_data[8*gi +: 8];
            end
         end
         assign desc_data[8*gi +: 8] = byte_reg;
      end
   endgenerate

   assign head          = head_reg;
   assign busy          = (state_reg != IDLE);
   assign mem_req_valid = mem_req_valid_reg;
   assign mem_req_addr  = cfg_base + {{(ADDR_W-PTR_W){1'b0}}, head_reg};
   assign desc_valid    = desc_valid_reg;
   assign desc_opcode   = desc_data[7:0];
   assign irq_cq_empty  = irq_cq_empty_reg;
   assign irq_cfg_err   = irq_cfg_err_reg;

endmodule
